// File: rtl/d16_bus_pkg.sv
// Shared types for the d16 Wishbone arbiter: FSM state encoding, master indices, bus widths.
package d16_bus_pkg;

    localparam int D16_AW = 16;
    localparam int D16_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    function automatic arb_state_e gnt_state(input master_e m);
        return (m == M0) ? GNT0 : GNT1;
    endfunction

endpackage

// File: rtl/d16_wb_arbiter_if.sv
// One Wishbone link (master <-> slave). The arbiter uses one per master and one toward the slave.
interface d16_wb_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic          stall;
    logic          err;

    modport master (output cyc, stb, we, addr, dat_w,
                    input  dat_r, ack, stall, err);

    modport slave  (input  cyc, stb, we, addr, dat_w,
                    output dat_r, ack, stall, err);
endinterface

// File: rtl/d16_arb_timeout.sv
// Ack watchdog for the arbiter: counts granted strobe cycles without ack and flags the TIMEOUT-th one.
module d16_arb_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr)
            cnt_d = '0;
        else if (i_inc)
            cnt_d = cnt_q + 8'd1;
    end

    // Fires during the stall cycle that brings the count up to TIMEOUT.
    assign o_expire = i_inc && (cnt_q == LIMIT);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/d16_wb_arbiter.sv
// Two-master / one-slave Wishbone arbiter for the d16 bus, round-robin on ties, grant held for the cyc.
// Optional ack watchdog enabled with `define D16_ARB_TIMEOUT_EN.
module d16_wb_arbiter
    import d16_bus_pkg::*;
#(
    parameter int AW      = D16_AW,
    parameter int DW      = D16_DW,
    parameter int TIMEOUT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    d16_wb_arbiter_if.slave       m0_bus,
    d16_wb_arbiter_if.slave       m1_bus,
    d16_wb_arbiter_if.master      s_bus
);
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("d16_wb_arbiter: TIMEOUT must be in 1..255");
    end

    arb_state_e state_q, state_d;
    master_e    last_q, last_d;

    master_e       sel;
    logic          granted;
    logic          own_cyc, own_stb, own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_dat;
    logic          fwd_ack;
    logic          expire;

    // Reset overrides the state so the slave cycle drops in the same cycle reset is seen.
    assign granted = !i_reset && (state_q != IDLE);
    assign sel     = (state_q == GNT1) ? M1 : M0;

    always_comb begin
        own_cyc  = m0_bus.cyc;
        own_stb  = m0_bus.stb;
        own_we   = m0_bus.we;
        own_addr = m0_bus.addr;
        own_dat  = m0_bus.dat_w;
        if (sel == M1) begin
            own_cyc  = m1_bus.cyc;
            own_stb  = m1_bus.stb;
            own_we   = m1_bus.we;
            own_addr = m1_bus.addr;
            own_dat  = m1_bus.dat_w;
        end
    end

    // Slave acks count only against the granted master's live strobe.
    assign fwd_ack = granted && own_cyc && own_stb && s_bus.ack;

`ifdef D16_ARB_TIMEOUT_EN
    d16_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (!granted || fwd_ack),
        .i_inc    (granted && own_cyc && own_stb && !s_bus.ack),
        .o_expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_bus.cyc && m1_bus.cyc) begin
                    last_d  = (last_q == M0) ? M1 : M0;
                    state_d = gnt_state(last_d);
                end else if (m0_bus.cyc) begin
                    last_d  = M0;
                    state_d = GNT0;
                end else if (m1_bus.cyc) begin
                    last_d  = M1;
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_cyc || expire)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= M1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign s_bus.cyc   = granted && own_cyc && !expire;
    assign s_bus.stb   = granted && own_stb && !expire;
    assign s_bus.we    = granted && own_we;
    assign s_bus.addr  = granted ? own_addr : '0;
    assign s_bus.dat_w = granted ? own_dat  : '0;

    assign m0_bus.ack   = fwd_ack && (sel == M0);
    assign m1_bus.ack   = fwd_ack && (sel == M1);
    assign m0_bus.err   = expire && (sel == M0);
    assign m1_bus.err   = expire && (sel == M1);
    assign m0_bus.stall = m0_bus.cyc && !(granted && (sel == M0));
    assign m1_bus.stall = m1_bus.cyc && !(granted && (sel == M1));
    assign m0_bus.dat_r = s_bus.dat_r;
    assign m1_bus.dat_r = s_bus.dat_r;
endmodule
